// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch (IF) and data (D) requesters.
// Define ARB_PERF_CNT_EN to add the perf_if_gnt / perf_d_gnt / perf_conflict counter outputs.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_gnt,
  output logic [31:0]       perf_d_gnt,
  output logic [31:0]       perf_conflict
`endif
);

  // Handshakes: a requester holds req (with stable addr/data) until it sees a one-cycle gnt;
  // mem_req holds stable until the edge where mem_ready=1; one mem_rvalid answers each access.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              owner_is_d_q, owner_is_d_d;
  logic              op_we_q, op_we_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic force_if;
  logic grant_d;
  logic grant_if;

  // Data normally wins; a fetch that has watched STARVE_MAX data grants go by takes the next slot.
  assign force_if = if_req && (starve_q == STARVE_LIM);
  assign grant_d  = (state_q == S_IDLE) && d_req && !force_if;
  assign grant_if = (state_q == S_IDLE) && if_req && !grant_d;

  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    op_we_d      = op_we_q;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          d_gnt_d      = 1'b1;
          owner_is_d_d = 1'b1;
          op_we_d      = d_we;
          state_d      = S_ISSUE;
        end else if (grant_if) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          if_gnt_d     = 1'b1;
          owner_is_d_d = 1'b0;
          op_we_d      = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (owner_is_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = op_we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Starvation count only runs while a fetch is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (!if_req) begin
      starve_d = '0;
    end else if (grant_if) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_is_d_q <= 1'b0;
      op_we_q      <= 1'b0;
      starve_q     <= '0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      op_we_q      <= op_we_d;
      starve_q     <= starve_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_gnt_q, perf_if_gnt_d;
  logic [31:0] perf_d_gnt_q, perf_d_gnt_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_if_gnt_d   = perf_if_gnt_q + {31'd0, grant_if};
    perf_d_gnt_d    = perf_d_gnt_q + {31'd0, grant_d};
    perf_conflict_d = perf_conflict_q + {31'd0, (state_q == S_IDLE) && if_req && d_req};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_gnt_q   <= '0;
      perf_d_gnt_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_if_gnt_q   <= perf_if_gnt_d;
      perf_d_gnt_q    <= perf_d_gnt_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_if_gnt   = perf_if_gnt_q;
  assign perf_d_gnt    = perf_d_gnt_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW     = 64;
  localparam int DW     = 64;
  localparam int STARVE = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_gnt, perf_d_gnt, perf_conflict;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_gnt(perf_if_gnt), .perf_d_gnt(perf_d_gnt), .perf_conflict(perf_conflict)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
    chk1({tag, "_d_gnt"}, d_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    chk64({tag, "_if_rdata"}, if_rdata, 64'h0);
    chk64({tag, "_d_rdata"}, d_rdata, 64'h0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk64({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk64({tag, "_mem_wdata"}, mem_wdata, 64'h0);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic reset_dut(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    tick();
    chk_all_zero(tag);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_req, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata, rdata;
    logic        exp_if, exp_d, exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_resp;
  } vec_t;

  vec_t vecs[5];

  // One full transaction from IDLE: grant, accept, response two cycles after acceptance.
  task automatic run_vec(input string tag, input vec_t v);
    if_req = v.if_req; d_req = v.d_req; d_we = v.d_we;
    if_addr = v.if_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    tick();
    chk1({tag, "_if_gnt"}, if_gnt, v.exp_if);
    chk1({tag, "_d_gnt"}, d_gnt, v.exp_d);
    chk1({tag, "_mem_req"}, mem_req, 1'b1);
    chk1({tag, "_mem_we"}, mem_we, v.exp_we);
    chk64({tag, "_mem_addr"}, mem_addr, v.exp_addr);
    chk64({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    tick();
    chk1({tag, "_acc_mem_req"}, mem_req, 1'b0);
    chk1({tag, "_acc_mem_we"}, mem_we, 1'b0);
    chk64({tag, "_acc_mem_wdata"}, mem_wdata, 64'h0);
    chk64({tag, "_acc_mem_addr"}, mem_addr, v.exp_addr);
    chk1({tag, "_acc_gnt"}, if_gnt | d_gnt, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk1({tag, "_wait_rvalid"}, if_rvalid | d_rvalid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = v.rdata;
    tick();
    chk1({tag, "_if_rvalid"}, if_rvalid, v.exp_if);
    chk1({tag, "_d_rvalid"}, d_rvalid, v.exp_d);
    if (v.exp_if) chk64({tag, "_if_rdata"}, if_rdata, v.exp_resp);
    else          chk64({tag, "_d_rdata"}, d_rdata, v.exp_resp);
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    chk1({tag, "_rvalid_pulse"}, if_rvalid | d_rvalid, 1'b0);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        accepted;
  } txn_t;

  txn_t        infl[$];
  logic [63:0] mem_m [logic [63:0]];
  logic [63:0] exp_q[$];
  int          m_starve;
  logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
  logic [63:0] e_mem_addr, e_if_rdata, e_d_rdata;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    txn_t t;
    logic d_wins;
    e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
    if (infl.size() == 0) begin
      d_wins = d_req && !(if_req && (m_starve == STARVE));
      if (d_wins) begin
        t = '{1'b1, d_we, d_addr, d_wdata, 1'b0};
        infl.push_back(t);
        e_d_gnt = 1'b1;
        e_mem_addr = d_addr;
      end else if (if_req) begin
        t = '{1'b0, 1'b0, if_addr, 64'h0, 1'b0};
        infl.push_back(t);
        e_if_gnt = 1'b1;
        e_mem_addr = if_addr;
      end
    end else if (!infl[0].accepted) begin
      if (mem_ready) begin
        t = infl[0];
        t.accepted = 1'b1;
        infl[0] = t;
        if (t.we) mem_m[t.addr] = t.wdata;
      end
    end else if (mem_rvalid) begin
      t = infl.pop_front();
      if (t.is_d) begin
        e_d_rv = 1'b1;
        e_d_rdata = t.we ? 64'h0 : mem_rdata;
        exp_q.push_back(e_d_rdata);
      end else begin
        e_if_rv = 1'b1;
        e_if_rdata = mem_rdata;
        exp_q.push_back(e_if_rdata);
      end
    end
    if (!if_req) m_starve = 0;
    else if (e_if_gnt) m_starve = 0;
    else if (e_d_gnt && m_starve < STARVE) m_starve = m_starve + 1;
  endtask

  // ---------------- stimulus ----------------
  int n_g;
  logic e_req;
  logic [63:0] got;

  initial begin
    #2;
    reset_dut("reset0");

    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0, 64'hDEAD_BEEF,
                1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 64'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h40, 64'h1234, 64'h5555_5555,
                1'b0, 1'b1, 1'b1, 64'h40, 64'h1234, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h88, 64'h777, 64'hCAFE_F00D,
                1'b0, 1'b1, 1'b0, 64'h88, 64'h777, 64'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h200, 64'h300, 64'hAB, 64'h9999,
                1'b0, 1'b1, 1'b1, 64'h300, 64'hAB, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h48, 64'h3C3C, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Simultaneous requests: D first, IF on the IDLE right after D's response.
    reset_dut("reset1");
    if_req = 1'b1; if_addr = 64'h3200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3100;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    chk1("simul_d_gnt", d_gnt, 1'b1);
    chk1("simul_if_gnt_early", if_gnt, 1'b0);
    d_req = 1'b0;
    tick();
    chk1("simul_stray_rvalid", d_rvalid, 1'b0);
    tick();
    chk1("simul_d_rvalid", d_rvalid, 1'b1);
    chk64("simul_d_rdata", d_rdata, 64'h77);
    chk1("simul_if_gnt_wait", if_gnt, 1'b0);
    tick();
    chk1("simul_if_gnt", if_gnt, 1'b1);
    chk64("simul_if_addr", mem_addr, 64'h3200);
    if_req = 1'b0; mem_rdata = 64'h88;
    tick();
    tick();
    chk1("simul_if_rvalid", if_rvalid, 1'b1);
    chk64("simul_if_rdata", if_rdata, 64'h88);
    chk1("simul_d_rvalid_quiet", d_rvalid, 1'b0);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Starvation guard: both held, grants must follow D,D,D,D,IF repeating.
    reset_dut("reset2");
    if_req = 1'b1; if_addr = 64'h2000; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3000;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    n_g = 0;
    for (int c = 0; c < 60 && n_g < 10; c++) begin
      tick();
      chk1("starve_excl", if_gnt & d_gnt, 1'b0);
      if (if_gnt || d_gnt) begin
        chk1($sformatf("starve_grant%0d_is_if", n_g), if_gnt, (n_g % 5 == 4));
        n_g++;
      end
    end
    chk64("starve_grant_count", 64'(n_g), 64'd10);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Backpressure: mem_ready low for 3 ISSUE cycles; a late IF request must wait.
    reset_dut("reset3");
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
    tick();
    chk1("bp_d_gnt", d_gnt, 1'b1);
    d_req = 1'b0; if_req = 1'b1; if_addr = 64'h600;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("bp_mem_req%0d", c), mem_req, 1'b1);
      chk64($sformatf("bp_mem_addr%0d", c), mem_addr, 64'h500);
      chk1($sformatf("bp_no_gnt%0d", c), if_gnt | d_gnt, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    chk1("bp_accept", mem_req, 1'b0);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1111;
    tick();
    chk1("bp_d_rvalid", d_rvalid, 1'b1);
    chk64("bp_d_rdata", d_rdata, 64'h1111);
    chk1("bp_if_waits", if_gnt, 1'b0);
    mem_rvalid = 1'b0;
    tick();
    chk1("bp_if_gnt", if_gnt, 1'b1);
    chk64("bp_if_addr", mem_addr, 64'h600);
    if_req = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h2222;
    tick();
    chk1("bp_if_rvalid", if_rvalid, 1'b1);
    chk64("bp_if_rdata", if_rdata, 64'h2222);
    mem_rvalid = 1'b0;
    tick();

    // Reset while waiting for the response; the late rvalid must be dropped.
    reset_dut("reset4");
    if_req = 1'b1; if_addr = 64'h700;
    tick();
    chk1("rstw_if_gnt", if_gnt, 1'b1);
    if_req = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstw_async");
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h9999;
    tick();
    chk1("rstw_late_if_rvalid", if_rvalid, 1'b0);
    chk1("rstw_late_d_rvalid", d_rvalid, 1'b0);
    chk64("rstw_late_if_rdata", if_rdata, 64'h0);
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    run_vec("rstw_next", vecs[1]);

    // Randomized run against the transaction-level model.
    reset_dut("reset5");
    infl.delete(); exp_q.delete(); mem_m.delete();
    m_starve = 0;
    e_if_gnt = 1'b0; e_d_gnt = 1'b0;
    e_mem_addr = '0; e_if_rdata = '0; e_d_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (e_if_gnt) if_req = 1'b0;
      if (e_d_gnt) d_req = 1'b0;
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1;
          if_addr = {$urandom, $urandom} & ~64'h7;
        end
      end else if ($urandom_range(0, 24) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 1'b1;
          d_we = ($urandom_range(0, 1) == 1);
          d_addr = 64'h1000 + 64'($urandom_range(0, 7) * 8);
          d_wdata = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 24) == 0) begin
        d_req = 1'b0;
      end
      mem_ready  = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 2) != 0);
      if (infl.size() != 0 && infl[0].accepted && !infl[0].we) mem_rdata = mem_rd(infl[0].addr);
      else mem_rdata = {$urandom, $urandom};
      model_edge();
      e_req = (infl.size() != 0) && !infl[0].accepted;
      tick();
      chk1($sformatf("rnd%0d_if_gnt", cyc), if_gnt, e_if_gnt);
      chk1($sformatf("rnd%0d_d_gnt", cyc), d_gnt, e_d_gnt);
      chk1($sformatf("rnd%0d_if_rvalid", cyc), if_rvalid, e_if_rv);
      chk1($sformatf("rnd%0d_d_rvalid", cyc), d_rvalid, e_d_rv);
      chk64($sformatf("rnd%0d_if_rdata", cyc), if_rdata, e_if_rdata);
      chk64($sformatf("rnd%0d_d_rdata", cyc), d_rdata, e_d_rdata);
      chk1($sformatf("rnd%0d_mem_req", cyc), mem_req, e_req);
      chk1($sformatf("rnd%0d_mem_we", cyc), mem_we, e_req && infl[0].we);
      chk64($sformatf("rnd%0d_mem_addr", cyc), mem_addr, e_mem_addr);
      chk64($sformatf("rnd%0d_mem_wdata", cyc), mem_wdata, e_req ? infl[0].wdata : 64'h0);
      if (if_rvalid || d_rvalid) begin
        got = if_rvalid ? if_rdata : d_rdata;
        if (exp_q.size() == 0) begin
          chk64($sformatf("rnd%0d_resp_unexpected", cyc), got, 64'h0);
          chk1($sformatf("rnd%0d_resp_queue", cyc), 1'b1, (exp_q.size() != 0));
        end else begin
          chk64($sformatf("rnd%0d_resp_data", cyc), got, exp_q.pop_front());
        end
      end
    end
    chk64("rnd_resp_queue_drained", 64'(exp_q.size()), 64'd0);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
